// File: rtl/btn_pkg.sv
// Shared types and helpers for the button event decoder.
package btn_pkg;

  // Decoder states: idle, held short, held long, waiting for a second press.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPressed = 2'd1,
    StLong    = 2'd2,
    StWait2   = 2'd3
  } button_state_t;

  // Largest of three cycle counts; sizes the shared phase counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rise/fall detector for a clk-synchronous level. Edges are masked for the
// first cycle after reset so a level held through reset is not seen as an edge.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic rise,
  output logic fall
);

  logic prev_q;
  logic armed_q;

  // Previous-sample register and post-reset arm flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= btn_in;
      armed_q <= 1'b1;
    end
  end

  assign rise = armed_q &  btn_in & ~prev_q;
  assign fall = armed_q & ~btn_in &  prev_q;

endmodule

// File: rtl/button_event.sv
// Button gesture decoder: press/release, short/long, auto-repeat while held
// and double press. All outputs are registered one cycle after the edge.
module button_event
  import btn_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned DOUBLE_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic double_pulse,
  output logic held
);

  localparam int unsigned CntW = $clog2(max3(LONG_CYCLES, REPEAT_CYCLES, DOUBLE_CYCLES)) + 1;
  // Thresholds are compared one cycle early because the pulse is registered.
  localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYCLES - 1);
  localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_CYCLES - 1);
  localparam logic [CntW-1:0] DblLast  = CntW'(DOUBLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};

  button_state_t   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Set when the current press came from WAIT2; its release must not re-arm.
  logic            no_win_q, no_win_d;
  logic            cnt_clr;
  logic            rise, fall;

  logic press_d, release_d, short_d, long_d, repeat_d, double_d, held_d;

  edge_detect u_edge_detect (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .rise   (rise),
    .fall   (fall)
  );

  // Next-state, counter and pulse decode; a fall always beats a threshold.
  always_comb begin
    state_d   = state_q;
    no_win_d  = no_win_q;
    held_d    = held;
    cnt_clr   = 1'b0;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    double_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d  = StPressed;
          press_d  = 1'b1;
          held_d   = 1'b1;
          no_win_d = 1'b0;
        end
      end
      StPressed: begin
        if (fall) begin
          release_d = 1'b1;
          short_d   = 1'b1;
          held_d    = 1'b0;
          state_d   = no_win_q ? StIdle : StWait2;
        end else if (cnt_q == LongLast) begin
          state_d = StLong;
          long_d  = 1'b1;
        end
      end
      StLong: begin
        if (fall) begin
          release_d = 1'b1;
          held_d    = 1'b0;
          state_d   = StIdle;
        end else if (cnt_q == RepLast) begin
          repeat_d = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      StWait2: begin
        if (rise) begin
          press_d  = 1'b1;
          double_d = 1'b1;
          held_d   = 1'b1;
          no_win_d = 1'b1;
          state_d  = StPressed;
        end else if (cnt_q == DblLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) cnt_clr = 1'b1;

    if (cnt_clr || state_q == StIdle) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      no_win_q      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      double_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      no_win_q      <= no_win_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      short_pulse   <= short_d;
      long_pulse    <= long_d;
      repeat_pulse  <= repeat_d;
      double_pulse  <= double_d;
      held          <= held_d;
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event with LONG=8, REPEAT=4, DOUBLE=6.
// Vector bits: {press, release, short, long, repeat, double, held}.
module tb_button_event;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic press_pulse, release_pulse, short_pulse, long_pulse;
  logic repeat_pulse, double_pulse, held;

  typedef struct {
    int         cyc;
    logic [6:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   done = 1'b0;

  localparam logic [6:0] PR = 7'b100_0001;  // press, held
  localparam logic [6:0] RS = 7'b011_0000;  // release + short
  localparam logic [6:0] RL = 7'b010_0000;  // release only
  localparam logic [6:0] LG = 7'b000_1001;  // long, held
  localparam logic [6:0] RP = 7'b000_0101;  // repeat, held
  localparam logic [6:0] DB = 7'b100_0011;  // press + double, held
  localparam logic [6:0] H1 = 7'b000_0001;
  localparam logic [6:0] H0 = 7'b000_0000;

  button_event #(
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .DOUBLE_CYCLES (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_pulse   (short_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .double_pulse  (double_pulse),
    .held          (held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each cycle, either match the scheduled expectation or demand silence.
  always @(negedge clk) begin
    logic [6:0] obs;
    exp_t       e;
    if (!done) begin
      obs = {press_pulse, release_pulse, short_pulse, long_pulse,
             repeat_pulse, double_pulse, held};
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL missed@%0d: event never checked, want %b", e.cyc, e.val);
      end
      n_chk++;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL event@%0d: got %b, want %b", cyc, obs, e.val);
        end
      end else if (obs[6:1] !== 6'b0) begin
        n_fail++;
        $display("FAIL spurious@%0d: got %b, want no pulse", cyc, obs);
      end
    end
  end

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic exp_ev(input int c, input logic [6:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    sb.push_back(e);
  endtask

  // Drive btn_in high for cycles s..e inclusive.
  task automatic hold_btn(input int s, input int e);
    at(s);
    btn_in = 1'b1;
    at(e + 1);
    btn_in = 1'b0;
  endtask

  initial begin
    int b;
    rst    = 1'b1;
    btn_in = 1'b0;
    exp_ev(2, H0);
    at(3);
    rst = 1'b0;

    // Short press.
    b = 10;
    exp_ev(b + 11, PR); exp_ev(b + 12, H1); exp_ev(b + 14, RS);
    hold_btn(b + 10, b + 12);

    // Long hold with repeats; release coincides with a repeat threshold.
    b = 70;
    exp_ev(b + 11, PR); exp_ev(b + 19, LG); exp_ev(b + 20, H1);
    exp_ev(b + 23, RP); exp_ev(b + 27, RP); exp_ev(b + 31, RL); exp_ev(b + 32, H0);
    hold_btn(b + 10, b + 29);

    // Double press, then a later press that must not be a double.
    b = 130;
    exp_ev(b + 11, PR); exp_ev(b + 13, RS); exp_ev(b + 16, DB);
    exp_ev(b + 18, RS); exp_ev(b + 21, PR); exp_ev(b + 22, RS);
    hold_btn(b + 10, b + 11);
    hold_btn(b + 15, b + 16);
    hold_btn(b + 20, b + 20);

    // Fall on the long threshold cycle: short wins.
    b = 190;
    exp_ev(b + 11, PR); exp_ev(b + 19, RS); exp_ev(b + 20, H0);
    hold_btn(b + 10, b + 17);

    // Second press on the last window cycle still counts as a double.
    b = 250;
    exp_ev(b + 11, PR); exp_ev(b + 12, RS); exp_ev(b + 18, DB); exp_ev(b + 19, RS);
    hold_btn(b + 10, b + 10);
    hold_btn(b + 17, b + 17);

    // One cycle past the window is a fresh press.
    b = 310;
    exp_ev(b + 11, PR); exp_ev(b + 12, RS); exp_ev(b + 19, PR); exp_ev(b + 20, RS);
    hold_btn(b + 10, b + 10);
    hold_btn(b + 18, b + 18);

    // Button held through reset: no pulses, held stays low.
    b = 370;
    exp_ev(b + 7, H0); exp_ev(b + 10, H0); exp_ev(b + 17, H0);
    at(b + 5);  rst = 1'b1;
    at(b + 6);  btn_in = 1'b1;
    at(b + 8);  rst = 1'b0;
    at(b + 15); btn_in = 1'b0;

    // Reset mid-hold aborts silently.
    b = 430;
    exp_ev(b + 11, PR); exp_ev(b + 13, H1); exp_ev(b + 15, H0);
    exp_ev(b + 20, H0); exp_ev(b + 27, H0);
    at(b + 10); btn_in = 1'b1;
    at(b + 14); rst = 1'b1;
    at(b + 17); rst = 1'b0;
    at(b + 25); btn_in = 1'b0;

    at(b + 40);
    #1;
    done = 1'b1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL leftover@%0d: event never checked, want %b", e.cyc, e.val);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
